// File: rtl/alu_pkg.sv
// alu_pkg: encodings shared by alu_seq and its iterative datapath.
//   op_e    - operation select (ADD, SUB, MUL, DIV)
//   state_e - sequencer states (IDLE, RUN, DONE)
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv: one-bit-per-cycle multiply / divide engine.
//   clk, rst_n     - clock, synchronous active-low reset
//   load           - capture operands a, b and the mode is_div; clear counter
//   step           - perform one iteration
//   is_div         - 0: shift-add multiply (LSB first), 1: restoring divide
//   a, b           - operands (multiplier/dividend a, multiplicand/divisor b)
//   last           - the iteration being stepped this cycle is the W-th one
//   res_hi, res_lo - value the accumulator / shift register take at this edge
//                    (MUL: product high/low halves; DIV: remainder/quotient)
module seq_muldiv #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic         is_div,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         last,
    output logic [W-1:0] res_hi,
    output logic [W-1:0] res_lo
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  acc_reg, acc_next;
    logic [W-1:0]  sh_reg, sh_next;
    logic [W-1:0]  b_reg;
    logic          div_reg;
    logic [CW-1:0] cnt_reg;

    logic [W:0]    mul_sum;
    logic [W:0]    div_shift;

    assign last = (cnt_reg == CW'(W - 1));

    always_comb begin
        acc_next  = acc_reg;
        sh_next   = sh_reg;
        mul_sum   = {1'b0, acc_reg} + (sh_reg[0] ? {1'b0, b_reg} : {(W+1){1'b0}});
        div_shift = {acc_reg, sh_reg[W-1]};
        if (step) begin
            if (div_reg) begin
                // Remainder stays below the divisor, so the W-bit difference is exact.
                if (div_shift >= {1'b0, b_reg}) begin
                    acc_next = div_shift[W-1:0] - b_reg;
                    sh_next  = {sh_reg[W-2:0], 1'b1};
                end else begin
                    acc_next = div_shift[W-1:0];
                    sh_next  = {sh_reg[W-2:0], 1'b0};
                end
            end else begin
                // Add-then-shift right; the carry drops into the accumulator MSB.
                acc_next = mul_sum[W:1];
                sh_next  = {mul_sum[0], sh_reg[W-1:1]};
            end
        end
    end

    assign res_hi = acc_next;
    assign res_lo = sh_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg <= '0;
            sh_reg  <= '0;
            b_reg   <= '0;
            div_reg <= 1'b0;
            cnt_reg <= '0;
        end else if (load) begin
            acc_reg <= '0;
            sh_reg  <= a;
            b_reg   <= b;
            div_reg <= is_div;
            cnt_reg <= '0;
        end else if (step) begin
            acc_reg <= acc_next;
            sh_reg  <= sh_next;
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU. ADD/SUB (and DIV by zero) finish one cycle after
// acceptance; MUL/DIV iterate W cycles in seq_muldiv first.
//   clk, rst_n  - clock, synchronous active-low reset
//   start       - request, sampled only in IDLE
//   op, sub_dir - operation select; sub_dir=1 computes B-A for SUB
//   A, B        - unsigned operands
//   busy, done  - state != IDLE, one-cycle result-valid pulse
//   y, rem      - result / DIV remainder (registered, held until next result)
//   neg, div0   - SUB sign, DIV-by-zero flag
module alu_seq import alu_pkg::*; #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic           sub_dir,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] y,
    output logic [W-1:0]   rem,
    output logic           neg,
    output logic           div0
);

    state_e       state_reg, state_next;
    op_e          op_reg;
    logic         load, step, last;
    logic [W-1:0] res_hi, res_lo;

    logic [W:0]   add_sum;
    logic [W:0]   sub_diff;
    logic [W-1:0] sub_mag;

    seq_muldiv #(.W(W)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .is_div (op_e'(op) == OP_DIV),
        .a      (A),
        .b      (B),
        .last   (last),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // Single-cycle results come straight from the operands at acceptance.
    always_comb begin
        add_sum  = {1'b0, A} + {1'b0, B};
        sub_diff = sub_dir ? ({1'b0, B} - {1'b0, A}) : ({1'b0, A} - {1'b0, B});
        // Magnitude never exceeds 2^W-1, so W-bit negation is exact.
        sub_mag  = sub_diff[W] ? ({W{1'b0}} - sub_diff[W-1:0]) : sub_diff[W-1:0];
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (op_e'(op) == OP_MUL || (op_e'(op) == OP_DIV && B != '0))
                        state_next = ST_RUN;
                    else
                        state_next = ST_DONE;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (last)
                    state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            op_reg    <= OP_ADD;
            y         <= '0;
            rem       <= '0;
            neg       <= 1'b0;
            div0      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load)
                op_reg <= op_e'(op);
            if (load && state_next == ST_DONE) begin
                case (op_e'(op))
                    OP_ADD: begin
                        y    <= {{(W-1){1'b0}}, add_sum};
                        rem  <= '0;
                        neg  <= 1'b0;
                        div0 <= 1'b0;
                    end
                    OP_SUB: begin
                        y    <= {{W{1'b0}}, sub_mag};
                        rem  <= '0;
                        neg  <= sub_diff[W];
                        div0 <= 1'b0;
                    end
                    default: begin
                        // Only DIV by zero reaches DONE directly besides ADD/SUB.
                        y    <= {{W{1'b0}}, {W{1'b1}}};
                        rem  <= A;
                        neg  <= 1'b0;
                        div0 <= 1'b1;
                    end
                endcase
            end
            if (step && last) begin
                neg  <= 1'b0;
                div0 <= 1'b0;
                if (op_reg == OP_MUL) begin
                    y   <= {res_hi, res_lo};
                    rem <= '0;
                end else begin
                    y   <= {{W{1'b0}}, res_lo};
                    rem <= res_hi;
                end
            end
        end
    end

    assign busy = (state_reg != ST_IDLE);
    assign done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // W=8 instance
    logic       start8, dir8;
    logic [1:0] op8;
    logic [7:0] a8, b8;
    logic       busy8, done8, neg8, div0_8;
    logic [15:0] y8;
    logic [7:0] rem8;

    // W=3 instance for the exhaustive sweep
    logic       start3, dir3;
    logic [1:0] op3;
    logic [2:0] a3, b3;
    logic       busy3, done3, neg3, div0_3;
    logic [5:0] y3;
    logic [2:0] rem3;

    alu_seq #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .sub_dir(dir8),
        .A(a8), .B(b8), .busy(busy8), .done(done8), .y(y8), .rem(rem8),
        .neg(neg8), .div0(div0_8)
    );

    alu_seq #(.W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .op(op3), .sub_dir(dir3),
        .A(a3), .B(b3), .busy(busy3), .done(done3), .y(y3), .rem(rem3),
        .neg(neg3), .div0(div0_3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0] op;
        logic       dir;
        logic [7:0] a;
        logic [7:0] b;
        int         y;
        int         rem;
        logic       neg;
        logic       div0;
        int         lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one W=8 request and wait (bounded) for done; inputs are scrambled
    // right after acceptance. lat=0 means done never came.
    task automatic run8(input logic [1:0] op, input logic dir, input logic [7:0] a,
                        input logic [7:0] b, output int lat, output int busy_bad);
        op8 = op; dir8 = dir; a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); op8 = 2'($urandom); dir8 = 1'($urandom);
        lat = 0;
        busy_bad = 0;
        for (int n = 1; n <= 20; n++) begin
            if (n > 1) begin @(posedge clk); #1; end
            if (!busy8) busy_bad++;
            if (done8) begin lat = n; break; end
        end
    endtask

    task automatic run3(input logic [1:0] op, input logic dir, input logic [2:0] a,
                        input logic [2:0] b, output int lat);
        op3 = op; dir3 = dir; a3 = a; b3 = b; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        a3 = 3'($urandom); b3 = 3'($urandom);
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            if (n > 1) begin @(posedge clk); #1; end
            if (done3) begin lat = n; break; end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bb, dones, dn;
        int ey, erem, eneg, ediv0, elat, d;

        vecs[0]  = '{2'b00, 1'b0, 8'd255, 8'd255, 510,   0,  1'b0, 1'b0, 1};
        vecs[1]  = '{2'b01, 1'b0, 8'd3,   8'd10,  7,     0,  1'b1, 1'b0, 1};
        vecs[2]  = '{2'b01, 1'b1, 8'd3,   8'd10,  7,     0,  1'b0, 1'b0, 1};
        vecs[3]  = '{2'b01, 1'b0, 8'd5,   8'd5,   0,     0,  1'b0, 1'b0, 1};
        vecs[4]  = '{2'b10, 1'b0, 8'd255, 8'd255, 65025, 0,  1'b0, 1'b0, 9};
        vecs[5]  = '{2'b10, 1'b0, 8'd0,   8'd17,  0,     0,  1'b0, 1'b0, 9};
        vecs[6]  = '{2'b10, 1'b1, 8'd13,  8'd11,  143,   0,  1'b0, 1'b0, 9};
        vecs[7]  = '{2'b11, 1'b0, 8'd200, 8'd7,   28,    4,  1'b0, 1'b0, 9};
        vecs[8]  = '{2'b11, 1'b0, 8'd13,  8'd0,   255,   13, 1'b0, 1'b1, 1};
        vecs[9]  = '{2'b11, 1'b0, 8'd5,   8'd9,   0,     5,  1'b0, 1'b0, 9};
        vecs[10] = '{2'b11, 1'b0, 8'd255, 8'd1,   255,   0,  1'b0, 1'b0, 9};
        vecs[11] = '{2'b00, 1'b1, 8'd0,   8'd0,   0,     0,  1'b0, 1'b0, 1};

        // Reset with start held high: the request must be ignored.
        rst_n = 1'b0;
        start8 = 1'b1; op8 = 2'b00; dir8 = 1'b0; a8 = 8'd1; b8 = 8'd1;
        start3 = 1'b0; op3 = 2'b00; dir3 = 1'b0; a3 = 3'd0; b3 = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", int'(busy8), 0);
        chk("reset done", int'(done8), 0);
        chk("reset y", int'(y8), 0);
        chk("reset rem", int'(rem8), 0);
        chk("reset neg", int'(neg8), 0);
        chk("reset div0", int'(div0_8), 0);
        chk("reset busy w3", int'(busy3), 0);
        rst_n = 1'b1;
        start8 = 1'b0;
        @(posedge clk); #1;
        chk("post-reset idle", int'(busy8), 0);

        // Directed W=8 vectors
        for (int i = 0; i < 12; i++) begin
            run8(vecs[i].op, vecs[i].dir, vecs[i].a, vecs[i].b, lat, bb);
            $display("txn w8 #%0d op=%0d dir=%0d A=%0d B=%0d -> y=%0d rem=%0d neg=%0d div0=%0d lat=%0d",
                     i, vecs[i].op, vecs[i].dir, vecs[i].a, vecs[i].b, y8, rem8, neg8, div0_8, lat);
            chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d y", i), int'(y8), vecs[i].y);
            chk($sformatf("v%0d rem", i), int'(rem8), vecs[i].rem);
            chk($sformatf("v%0d neg", i), int'(neg8), int'(vecs[i].neg));
            chk($sformatf("v%0d div0", i), int'(div0_8), int'(vecs[i].div0));
            chk($sformatf("v%0d busy gaps", i), bb, 0);
            @(posedge clk); #1;
            chk($sformatf("v%0d done pulse width", i), int'(done8), 0);
            chk($sformatf("v%0d idle after done", i), int'(busy8), 0);
            chk($sformatf("v%0d y held", i), int'(y8), vecs[i].y);
        end

        // MUL with start held high and operands changing during the run
        op8 = 2'b10; dir8 = 1'b0; a8 = 8'd12; b8 = 8'd10; start8 = 1'b1;
        @(posedge clk); #1;
        dones = 0; dn = 0;
        for (int n = 1; n <= 9; n++) begin
            if (n > 1) begin @(posedge clk); #1; end
            if (done8) begin dones++; dn = n; end
            a8 = 8'($urandom); b8 = 8'($urandom);
        end
        $display("txn w8 held-start MUL 12*10 -> y=%0d dones=%0d at=%0d", y8, dones, dn);
        chk("held-start done count", dones, 1);
        chk("held-start done latency", dn, 9);
        chk("held-start y", int'(y8), 120);
        @(posedge clk); #1;
        chk("held-start not queued", int'(busy8), 0);
        run8(2'b10, 1'b0, 8'd3, 8'd4, lat, bb);
        $display("txn w8 MUL 3*4 after held start -> y=%0d lat=%0d", y8, lat);
        chk("next-after-idle latency", lat, 9);
        chk("next-after-idle y", int'(y8), 12);
        @(posedge clk); #1;

        // Reset pulse in the middle of a DIV
        op8 = 2'b11; a8 = 8'd200; b8 = 8'd7; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("mid-run busy", int'(busy8), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort busy", int'(busy8), 0);
        chk("abort y", int'(y8), 0);
        chk("abort rem", int'(rem8), 0);
        chk("abort neg", int'(neg8), 0);
        chk("abort div0", int'(div0_8), 0);
        dones = 0;
        for (int n = 0; n < 12; n++) begin
            if (done8) dones++;
            @(posedge clk); #1;
        end
        chk("abort no done", dones, 0);
        run8(2'b00, 1'b0, 8'd1, 8'd2, lat, bb);
        $display("txn w8 ADD 1+2 after abort -> y=%0d lat=%0d", y8, lat);
        chk("after-abort latency", lat, 1);
        chk("after-abort y", int'(y8), 3);
        @(posedge clk); #1;

        // Exhaustive W=3 sweep against an arithmetic reference
        for (int op = 0; op < 4; op++) begin
            for (int dir = 0; dir < 2; dir++) begin
                for (int a = 0; a < 8; a++) begin
                    for (int b = 0; b < 8; b++) begin
                        erem = 0; eneg = 0; ediv0 = 0; elat = 1;
                        case (op)
                            0: ey = a + b;
                            1: begin
                                d = (dir != 0) ? (b - a) : (a - b);
                                eneg = (d < 0) ? 1 : 0;
                                ey = (d < 0) ? -d : d;
                            end
                            2: begin ey = a * b; elat = 4; end
                            default: begin
                                if (b == 0) begin
                                    ey = 7; erem = a; ediv0 = 1;
                                end else begin
                                    ey = a / b; erem = a % b; elat = 4;
                                end
                            end
                        endcase
                        run3(2'(op), 1'(dir), 3'(a), 3'(b), lat);
                        $display("txn w3 op=%0d dir=%0d A=%0d B=%0d -> y=%0d rem=%0d neg=%0d div0=%0d lat=%0d",
                                 op, dir, a, b, y3, rem3, neg3, div0_3, lat);
                        chk($sformatf("w3 op%0d d%0d %0d,%0d lat", op, dir, a, b), lat, elat);
                        chk($sformatf("w3 op%0d d%0d %0d,%0d y", op, dir, a, b), int'(y3), ey);
                        chk($sformatf("w3 op%0d d%0d %0d,%0d rem", op, dir, a, b), int'(rem3), erem);
                        chk($sformatf("w3 op%0d d%0d %0d,%0d neg", op, dir, a, b), int'(neg3), eneg);
                        chk($sformatf("w3 op%0d d%0d %0d,%0d div0", op, dir, a, b), int'(div0_3), ediv0);
                        @(posedge clk); #1;
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
